// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes, instruction fields, FSM states and PSR bit indices
package alu_pkg;

    localparam int DATA_W = 16;
    localparam int NREGS  = 16;
    localparam int REG_AW = 4;
    localparam int OPC_W  = 8;

    // ALU opcode codes, shared with the combinational ALU
    localparam logic [OPC_W-1:0] OP_ADD    = 8'd0;
    localparam logic [OPC_W-1:0] OP_ADDU   = 8'd1;
    localparam logic [OPC_W-1:0] OP_ADDC   = 8'd2;
    localparam logic [OPC_W-1:0] OP_ADDCU  = 8'd3;
    localparam logic [OPC_W-1:0] OP_SUB    = 8'd4;
    localparam logic [OPC_W-1:0] OP_CMP    = 8'd5;
    localparam logic [OPC_W-1:0] OP_CMPU   = 8'd6;
    localparam logic [OPC_W-1:0] OP_AND    = 8'd7;
    localparam logic [OPC_W-1:0] OP_OR     = 8'd8;
    localparam logic [OPC_W-1:0] OP_XOR    = 8'd9;
    localparam logic [OPC_W-1:0] OP_NOT    = 8'd10;
    localparam logic [OPC_W-1:0] OP_LSH    = 8'd11;
    localparam logic [OPC_W-1:0] OP_RSH    = 8'd12;
    localparam logic [OPC_W-1:0] OP_ALSH   = 8'd13;
    localparam logic [OPC_W-1:0] OP_ARSH   = 8'd14;
    localparam logic [OPC_W-1:0] OP_ADDI   = 8'd15;
    localparam logic [OPC_W-1:0] OP_ADDUI  = 8'd16;
    localparam logic [OPC_W-1:0] OP_ADDCUI = 8'd17;
    localparam logic [OPC_W-1:0] OP_SUBI   = 8'd18;
    localparam logic [OPC_W-1:0] OP_CMPI   = 8'd19;
    localparam logic [OPC_W-1:0] OP_CMPUI  = 8'd20;
    localparam logic [OPC_W-1:0] OP_LSHI   = 8'd21;
    localparam logic [OPC_W-1:0] OP_RSHI   = 8'd22;
    localparam logic [OPC_W-1:0] OP_NOP    = 8'd24;

    // Instruction field positions
    localparam int F_MAJ_LO = 12;
    localparam int F_RD_LO  = 8;
    localparam int F_EXT_LO = 4;
    localparam int F_RS_LO  = 0;

    // Major codes
    localparam logic [3:0] MAJ_REG    = 4'h0;
    localparam logic [3:0] MAJ_ADDI   = 4'h1;
    localparam logic [3:0] MAJ_ADDUI  = 4'h2;
    localparam logic [3:0] MAJ_ADDCUI = 4'h3;
    localparam logic [3:0] MAJ_SUBI   = 4'h4;
    localparam logic [3:0] MAJ_CMPI   = 4'h5;
    localparam logic [3:0] MAJ_CMPUI  = 4'h6;
    localparam logic [3:0] MAJ_LSHI   = 4'h7;
    localparam logic [3:0] MAJ_RSHI   = 4'h8;

    // PSR bit indices, Psr = {Carry, Flag, Low, Negative, Zero}
    localparam int PSR_CARRY = 4;
    localparam int PSR_FLAG  = 3;
    localparam int PSR_LOW   = 2;
    localparam int PSR_NEG   = 1;
    localparam int PSR_ZERO  = 0;

    typedef enum logic [1:0] {ST_IDLE, ST_DECODE, ST_EXEC, ST_WB} state_t;

    // Writeback class: which register/PSR fields an op touches
    typedef enum logic [1:0] {CLS_NONE, CLS_ARITH, CLS_CMP, CLS_LOGIC} cls_t;

    function automatic logic [OPC_W-1:0] regop_code(input logic [3:0] ext);
        case (ext)
            4'h0: return OP_ADD;
            4'h1: return OP_ADDU;
            4'h2: return OP_ADDC;
            4'h3: return OP_ADDCU;
            4'h4: return OP_SUB;
            4'h5: return OP_CMP;
            4'h6: return OP_CMPU;
            4'h7: return OP_AND;
            4'h8: return OP_OR;
            4'h9: return OP_XOR;
            4'hA: return OP_NOT;
            4'hB: return OP_LSH;
            4'hC: return OP_RSH;
            4'hD: return OP_ALSH;
            4'hE: return OP_ARSH;
            default: return OP_NOP;
        endcase
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - 16x16 register file, two async read ports, debug read port, one sync write port
// Ports: clk, rst_n (sync clear), ra/rb read ports, dbg read port, we/wa/wd write port.
module alu_regfile
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [REG_AW-1:0] rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [DATA_W-1:0] wd
);

    logic [DATA_W-1:0] mem [NREGS];

    assign ra_data  = mem[ra_addr];
    assign rb_data  = mem[rb_addr];
    assign dbg_data = mem[dbg_addr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wa] <= wd;
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - four-state issue/writeback controller driving the combinational ALU
// Ports: Instr/Instr_valid/Instr_ready fetch handshake; Alu_A/B/Opcode/CarryIn to ALU;
//        Alu_C and flags from ALU; Psr status; Done/Illegal retire pulses; Dbg_addr/Dbg_data debug read.
module alu_issue_ctrl
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       Instr,
    input  logic              Instr_valid,
    output logic              Instr_ready,
    output logic [DATA_W-1:0] Alu_A,
    output logic [DATA_W-1:0] Alu_B,
    output logic [OPC_W-1:0]  Alu_Opcode,
    output logic              Alu_CarryIn,
    input  logic [DATA_W-1:0] Alu_C,
    input  logic              Alu_Carry,
    input  logic              Alu_Flag,
    input  logic              Alu_Low,
    input  logic              Alu_Negative,
    input  logic              Alu_Zero,
    output logic [4:0]        Psr,
    output logic              Done,
    output logic              Illegal,
    input  logic [REG_AW-1:0] Dbg_addr,
    output logic [DATA_W-1:0] Dbg_data
);

    state_t            state, state_nx;
    logic [15:0]       ir;
    logic [DATA_W-1:0] res_c;
    logic [4:0]        res_fl;

    logic [3:0]        maj, rd, ext, rs;
    logic [7:0]        imm8;
    logic [OPC_W-1:0]  dec_op;
    logic [DATA_W-1:0] dec_imm;
    logic              dec_use_imm;
    logic              dec_ill;
    cls_t              dec_cls;
    logic              dec_wr;
    logic [DATA_W-1:0] ra_data, rb_data;

    assign maj  = ir[F_MAJ_LO +: 4];
    assign rd   = ir[F_RD_LO  +: 4];
    assign ext  = ir[F_EXT_LO +: 4];
    assign rs   = ir[F_RS_LO  +: 4];
    assign imm8 = ir[7:0];

    // Decode is driven from the latched instruction so WB still sees the same class.
    always_comb begin
        dec_op      = OP_NOP;
        dec_imm     = '0;
        dec_use_imm = 1'b0;
        dec_ill     = 1'b0;
        dec_cls     = CLS_NONE;
        case (maj)
            MAJ_REG: begin
                dec_op = regop_code(ext);
                if (ext <= 4'h4)                       dec_cls = CLS_ARITH;
                else if (ext == 4'h5 || ext == 4'h6)   dec_cls = CLS_CMP;
                else if (ext != 4'hF)                  dec_cls = CLS_LOGIC;
            end
            MAJ_ADDI:   begin dec_op = OP_ADDI;   dec_use_imm = 1'b1; dec_imm = {{8{imm8[7]}}, imm8}; dec_cls = CLS_ARITH; end
            MAJ_ADDUI:  begin dec_op = OP_ADDUI;  dec_use_imm = 1'b1; dec_imm = {8'd0, imm8};         dec_cls = CLS_ARITH; end
            MAJ_ADDCUI: begin dec_op = OP_ADDCUI; dec_use_imm = 1'b1; dec_imm = {8'd0, imm8};         dec_cls = CLS_ARITH; end
            MAJ_SUBI:   begin dec_op = OP_SUBI;   dec_use_imm = 1'b1; dec_imm = {{8{imm8[7]}}, imm8}; dec_cls = CLS_ARITH; end
            MAJ_CMPI:   begin dec_op = OP_CMPI;   dec_use_imm = 1'b1; dec_imm = {{8{imm8[7]}}, imm8}; dec_cls = CLS_CMP;   end
            MAJ_CMPUI:  begin dec_op = OP_CMPUI;  dec_use_imm = 1'b1; dec_imm = {8'd0, imm8};         dec_cls = CLS_CMP;   end
            MAJ_LSHI:   begin dec_op = OP_LSHI;   dec_use_imm = 1'b1; dec_imm = {12'd0, ir[3:0]};     dec_cls = CLS_LOGIC; end
            MAJ_RSHI:   begin dec_op = OP_RSHI;   dec_use_imm = 1'b1; dec_imm = {12'd0, ir[3:0]};     dec_cls = CLS_LOGIC; end
            default:    dec_ill = 1'b1;
        endcase
    end

    assign dec_wr = (dec_cls == CLS_ARITH) || (dec_cls == CLS_LOGIC);

    alu_regfile u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra_addr  (rd),
        .ra_data  (ra_data),
        .rb_addr  (rs),
        .rb_data  (rb_data),
        .dbg_addr (Dbg_addr),
        .dbg_data (Dbg_data),
        .we       ((state == ST_WB) && dec_wr),
        .wa       (rd),
        .wd       (res_c)
    );

    always_comb begin
        state_nx    = state;
        Instr_ready = 1'b0;
        Done        = 1'b0;
        Illegal     = 1'b0;
        case (state)
            ST_IDLE: begin
                Instr_ready = 1'b1;
                if (Instr_valid) state_nx = ST_DECODE;
            end
            ST_DECODE: state_nx = ST_EXEC;
            ST_EXEC:   state_nx = ST_WB;
            ST_WB: begin
                Done     = 1'b1;
                Illegal  = dec_ill;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign Alu_CarryIn = Psr[PSR_CARRY];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            ir         <= '0;
            Alu_A      <= '0;
            Alu_B      <= '0;
            Alu_Opcode <= OP_NOP;
            res_c      <= '0;
            res_fl     <= '0;
            Psr        <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && Instr_valid) begin
                ir <= Instr;
            end
            if (state == ST_DECODE) begin
                Alu_A      <= ra_data;
                Alu_B      <= dec_use_imm ? dec_imm : rb_data;
                Alu_Opcode <= dec_op;
            end
            if (state == ST_EXEC) begin
                res_c  <= Alu_C;
                res_fl <= {Alu_Carry, Alu_Flag, Alu_Low, Alu_Negative, Alu_Zero};
            end
            if (state == ST_WB) begin
                if (dec_cls == CLS_ARITH) begin
                    Psr[PSR_CARRY] <= res_fl[PSR_CARRY];
                    Psr[PSR_FLAG]  <= res_fl[PSR_FLAG];
                    Psr[PSR_ZERO]  <= res_fl[PSR_ZERO];
                end else if (dec_cls == CLS_CMP) begin
                    Psr[PSR_LOW]   <= res_fl[PSR_LOW];
                end
            end
        end
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Multi-cycle instruction issue and writeback controller that drives the team's combinational ALU. It accepts one 16-bit instruction per valid/ready handshake and decodes it into the 8-bit ALU opcode and the A/B operands. It holds the 16x16 register file and the processor status register (PSR), captures the ALU result and flags, and writes them back. It sits between the fetch stage upstream and the ALU downstream.

Parameters:
DATA_W, 16, datapath width (A, B, C, registers)
NREGS, 16, register count (address width log2(NREGS)=4)
OPC_W, 8, ALU opcode width

Ports:
clk  in  1  system clock, all state changes on rising edge
rst_n  in  1  synchronous reset, active low
Instr  in  16  instruction word
Instr_valid  in  1  upstream has an instruction
Instr_ready  out  1  controller accepts Instr this cycle
Alu_A  out  16  ALU operand A (R[Rdest])
Alu_B  out  16  ALU operand B (R[Rsrc] or extended immediate)
Alu_Opcode  out  8  ALU opcode
Alu_CarryIn  out  1  PSR.Carry, consumed for ADDC/ADDCU/ADDCUI
Alu_C  in  16  ALU result
Alu_Carry, Alu_Flag, Alu_Low, Alu_Negative, Alu_Zero  in  1 each  ALU flags
Psr  out  5  {Carry,Flag,Low,Negative,Zero}
Done  out  1  one-cycle pulse, instruction retiring
Illegal  out  1  one-cycle pulse with Done, undefined encoding
Dbg_addr  in  4  debug register select
Dbg_data  out  16  R[Dbg_addr], asynchronous read

Behaviour:
- Reset: synchronous, active low (rst_n sampled on clk rising edge). Effects: state=IDLE; all registers=0; Psr=0; Alu_A=Alu_B=0; Alu_Opcode=NOP(24); Done=Illegal=0; Instr_ready=1 in the first cycle after reset.
- Fields: Instr[15:12] major, [11:8] Rdest, [7:4] OpExt, [3:0] Rsrc, [7:0] Imm8.
- Major 0 (register form), OpExt to ALU code: 0 ADD, 1 ADDU, 2 ADDC, 3 ADDCU, 4 SUB, 5 CMP, 6 CMPU, 7 AND, 8 OR, 9 XOR, A NOT, B LSH, C RSH, D ALSH, E ARSH, F NOP.
- Immediate majors: 1 ADDI, 2 ADDUI, 3 ADDCUI, 4 SUBI, 5 CMPI, 6 CMPUI, 7 LSHI, 8 RSHI.
- Immediate extension: ADDI/SUBI/CMPI use sign-extended Imm8. ADDUI/ADDCUI/CMPUI use zero-extended Imm8. LSHI/RSHI use zero-extended Instr[3:0].
- Majors 9-F are illegal: executed as NOP, Illegal pulses.
- FSM: IDLE -> DECODE -> EXEC -> WB -> IDLE.
  - IDLE: Instr_ready=1. Instr_valid&Instr_ready at an edge latches Instr; go to DECODE.
  - DECODE: read regfile; register Alu_A, Alu_B, Alu_Opcode at the edge; go to EXEC.
  - EXEC: ALU inputs stable for the whole cycle; latch Alu_C and flags at the edge; go to WB.
  - WB: Done=1 (Illegal=1 if illegal). At the edge: write R[Rdest] and update Psr; go to IDLE.
- Latency: handshake at edge T0; Done high in cycle T3; result visible on Dbg_data from T4. Throughput is 1 instruction per 4 cycles.
- Writeback rules:
  - Register written for all ops except CMP/CMPU/CMPI/CMPUI/NOP/illegal.
  - ADD-class and SUB-class update Psr.Carry, Flag, Zero.
  - CMP-class updates Psr.Low only.
  - Logic and shift ops leave Psr unchanged.
  - NOP and illegal change nothing.
- Instr_ready is low outside IDLE; Instr_valid is ignored there and must be held by upstream.
- Rdest==Rsrc is legal; operands are read before the write.
- Reset mid-instruction (any state) aborts: no register or Psr write, no Done.
- Dbg read is combinational and returns the pre-write value during WB.

Decomposition:
- Shared package alu_pkg: ALU opcode constants (shared with the ALU), instruction field bit positions, major/OpExt codes, FSM state encoding, PSR bit indices.
- One sub-module: alu_regfile — 16x16, two async read ports plus debug port, one sync write port, synchronous active-low clear.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles, release -> Instr_ready=1, Psr=0, Dbg_data=0 for all 16 addresses, Alu_Opcode=24.
- ADDI latency: Instr=0x117F, then 0x1101 -> R1=0x0080. Done exactly 3 cycles after each handshake edge. Then 0x12FF -> R2=0xFFFF (sign extension).
- ADDUI carry: 0x13FF (R3=0xFFFF), then 0x2301 -> R3=0x0000, Psr.Carry=1, Psr.Zero=1.
- Compare: R1=0x0080, R2=0xFFFF. Instr 0x0251 (CMP R2,R1) -> Psr.Low=1, R2 unchanged. Instr 0x0261 (CMPU) -> Psr.Low=0.
- Illegal/handshake: 0x9ABC -> Illegal and Done pulse together, no register or Psr change. Instr_valid asserted during DECODE/EXEC/WB is not accepted until IDLE.
- Reset mid-op: issue 0x1155, drive rst_n=0 during EXEC -> R1 stays 0, no Done, IDLE after release.
